uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the host COM link: the return direction of the 9600-baud serial receiver that feeds the APU. It accepts bytes over a valid/ready handshake into a small FIFO and transmits them as 8N1 frames (one start bit, 8 data bits LSB first, one stop bit) on a single line. It runs from the 12 MHz system oscillator clock and sits beside the APU to report status or echo data back to the host.

## Interface
- OSCRATE, 12_000_000: system clock frequency in Hz.
- BAUDRATE, 9600: serial bit rate.
  - DIV = OSCRATE/BAUDRATE (integer division) is the clocks per bit; 1250 at defaults.
  - DIV must be >= 2.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  FIFO can accept a byte; high when FIFO not full.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO. The byte being shifted out is excluded.

## Operation
- Reset values, applied immediately on rst high:
  - tx=1, tx_ready=1, busy=0, fifo_level=0.
  - FIFO is emptied.
  - FSM is in IDLE.
  - Bit counter and divisor counter are 0.
- FIFO:
  - Push on a rising edge when tx_valid && tx_ready.
  - Pop when the FSM loads a byte.
  - tx_ready is derived from the registered level only; there is no bypass. When full, a same-cycle pop does not enable a push in that cycle.
  - Push and pop in the same cycle: level is unchanged and data order is preserved.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head byte into the shift register, drive tx=0 and go to START.
  - START: hold tx=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: drive tx = shift[index] for DIV clocks each. Index runs 0..7, LSB first. After bit 7 completes, go to STOP.
  - STOP: tx=1 for DIV clocks. At the end of the stop bit:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Divisor counter:
  - Counts 0..DIV-1 and wraps.
  - Width is $clog2(DIV).
  - Restarts at 0 on every state/bit transition.
- tx is a registered output, glitch-free.
- tx_data changes while not accepted are ignored.
- A byte already loaded is unaffected by later FIFO activity.
- Reset mid-frame: the frame is abandoned, tx returns high immediately, and queued bytes are discarded.

## Timing
- Accept at edge E0 with FSM idle: tx falls after edge E1 (one clock latency). fifo_level reads 1 after E0 and 0 after E1.
- Each bit is exactly DIV clocks. A full frame is exactly 10*DIV clocks (12500 at defaults).
- Back-to-back frames: the next start bit begins on the clock immediately after the final stop-bit clock. The period is exactly 10*DIV clocks per byte.
- busy rises on the edge after the first accepted byte. It falls on the edge that returns the FSM to IDLE with an empty FIFO.
- Throughput: FIFO_DEPTH+1 bytes can be accepted without stall (FIFO plus the shift register).

## Test plan
- Reset, then push 0x55 with DIV=4 (OSCRATE=16, BAUDRATE=4) -> tx goes low 1 clock after accept. Line sequence is 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each level held 4 clocks. busy deasserts 40 clocks after tx falls.
- Push 0x00 then 0xFF back-to-back -> frames are contiguous with no idle clocks. Bits are correct; second start bit begins exactly 40 clocks after the first.
- Hold tx_valid high with 6 distinct bytes while idle -> 5 accepted immediately (1 loaded, 4 queued). tx_ready drops with fifo_level=4. The 6th byte is accepted only after the first frame ends. All 6 appear in order.
- Simultaneous push and pop at fifo_level=2 -> fifo_level stays 2 and the transmitted order matches the push order.
- Assert rst mid data bit 3 -> tx=1, tx_ready=1, busy=0, fifo_level=0 immediately. After release, a new byte 0xA3 transmits cleanly.
- Default parameters, push 0x41 -> start bit width is 1250 clocks and the frame is 12500 clocks. A bench UART receiver at 9600 baud decodes 0x41.

Source files
------------

// File: rtl/uart_tx_if.sv
`default_nettype none
// ==========================================================================
// uart_tx_if : byte handshake between a producer and the uart_tx FIFO
// Revision   : 1.0 - initial release
// ==========================================================================
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ==========================================================================
// uart_tx  : FIFO-buffered 8N1 serial transmitter, back-to-back frames
// Revision : 1.0 - initial release
// ==========================================================================
module uart_tx #(
  parameter int OSCRATE    = 12_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                          clk,
  input  wire logic                          rst,
  uart_tx_if.slave                           bus,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

  localparam int DIV = OSCRATE / BAUDRATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_div, w_div;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          r_tx, w_tx;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;

  logic w_push, w_pop, w_not_empty, w_div_end;

  // Ready depends only on the registered level, so a full FIFO never
  // accepts in the same cycle it is popped.
  assign bus.tx_ready = (r_level != LVL_FULL);
  assign w_push       = bus.tx_valid && bus.tx_ready;
  assign w_not_empty  = (r_level != '0);
  assign w_div_end    = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
    end
  end

  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_tx    = r_tx;
    w_pop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx = 1'b1;
        if (w_not_empty) begin
          w_pop   = 1'b1;
          w_shift = r_mem[r_rd];
          w_tx    = 1'b0;
          w_div   = '0;
          w_state = S_START;
        end
      end
      S_START: begin
        if (w_div_end) begin
          w_div   = '0;
          w_bit   = '0;
          w_tx    = r_shift[0];
          w_state = S_DATA;
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_DATA: begin
        if (w_div_end) begin
          w_div = '0;
          if (r_bit == 3'd7) begin
            w_tx    = 1'b1;
            w_state = S_STOP;
          end else begin
            w_bit = r_bit + 3'd1;
            w_tx  = r_shift[w_bit];
          end
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_STOP: begin
        if (w_div_end) begin
          w_div = '0;
          // Next start bit follows the last stop clock with no idle gap.
          if (w_not_empty) begin
            w_pop   = 1'b1;
            w_shift = r_mem[r_rd];
            w_tx    = 1'b0;
            w_state = S_START;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
      end
    endcase
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || w_not_empty;
  assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ==========================================================================
// tb_uart_tx : directed + randomized bench with frame-timer reference model
// Revision   : 1.0 - initial release
// ==========================================================================
module tb_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int DDIV  = 1250;

  logic       clk;
  logic       rst;
  logic       tx_a, busy_a, tx_d, busy_d;
  logic [2:0] level_a, level_d;

  uart_tx_if bus_a ();
  uart_tx_if bus_d ();

  uart_tx #(.OSCRATE(16), .BAUDRATE(4), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .tx(tx_a), .busy(busy_a), .fifo_level(level_a)
  );

  uart_tx dut_d (
    .clk(clk), .rst(rst), .bus(bus_d), .tx(tx_d), .busy(busy_d), .fifo_level(level_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference: a queue of waiting bytes plus a frame timer; the line level
  // is a pure function of the byte and the time into its 10*DIV frame.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur;
  bit         m_active;
  bit         m_acc;
  int         m_t;

  function automatic logic line_bit(input logic [7:0] b, input int t);
    int k;
    k = t / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    m_active = 1'b0;
    m_t      = 0;
    m_cur    = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_sent.delete();
        m_active = 1'b0;
        m_t      = 0;
      end else begin
        m_acc = bus_a.tx_valid && (m_q.size() < DEPTH);
        if (m_active) begin
          m_t++;
          if (m_t == 10 * DIV) begin
            if (m_q.size() > 0) begin
              m_cur = m_q.pop_front();
              m_t   = 0;
            end else begin
              m_active = 1'b0;
            end
          end
        end else if (m_q.size() > 0) begin
          m_cur    = m_q.pop_front();
          m_active = 1'b1;
          m_t      = 0;
        end
        if (m_acc) begin
          m_q.push_back(bus_a.tx_data);
          m_sent.push_back(bus_a.tx_data);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("tx", tx_a, m_active ? line_bit(m_cur, m_t) : 1'b1);
    check("tx_ready", bus_a.tx_ready, (m_q.size() < DEPTH));
    check("busy", busy_a, (m_active || m_q.size() > 0));
    check("fifo_level", level_a, m_q.size());
  end

  // Line receiver: samples mid-bit and matches bytes against accept order.
  bit         rx_on = 1'b0;
  int         rx_c, rx_k;
  logic [7:0] rx_b;
  logic [7:0] rx_exp;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rx_on = 1'b0;
    end else begin
      if (!rx_on && tx_a == 1'b0) begin
        rx_on = 1'b1;
        rx_c  = 0;
      end else if (rx_on) begin
        rx_c++;
      end
      if (rx_on && (rx_c % DIV) == DIV / 2) begin
        rx_k = rx_c / DIV;
        if (rx_k == 0) check("rx_start", tx_a, 1'b0);
        else if (rx_k <= 8) rx_b[rx_k-1] = tx_a;
        else begin
          check("rx_stop", tx_a, 1'b1);
          if (m_sent.size() == 0) check("rx_extra", m_sent.size(), 1);
          else begin
            rx_exp = m_sent.pop_front();
            check("rx_byte", rx_b, rx_exp);
          end
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic push_a(input logic [7:0] b);
    int n;
    bus_a.tx_data  = b;
    bus_a.tx_valid = 1'b1;
    n = 0;
    while (bus_a.tx_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("push_timeout", n, 0);
    @(negedge clk);
    last_acc = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a || m_active || m_q.size() > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n < 3000), 1);
    repeat (2) @(negedge clk);
    check("rx_pending", m_sent.size(), 0);
  endtask

  task automatic wait_t(input int t);
    int n;
    n = 0;
    while (!(m_active && m_t == t) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("wait_t_timeout", (n < 1000), 1);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_tx"}, tx_a, 1'b1);
    check({tag, "_ready"}, bus_a.tx_ready, 1'b1);
    check({tag, "_busy"}, busy_a, 1'b0);
    check({tag, "_level"}, level_a, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  int         acc1;
  int         sw;
  logic [7:0] rxd;
  logic       s0, s9;

  initial begin
    rst            = 1'b1;
    bus_a.tx_valid = 1'b0;
    bus_a.tx_data  = '0;
    bus_d.tx_valid = 1'b0;
    bus_d.tx_data  = '0;
    @(negedge clk);
    check("rst_tx", tx_a, 1'b1);
    check("rst_ready", bus_a.tx_ready, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_level", level_a, 0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0x55 frame: one-clock latency, alternating line, busy span.
    push_a(8'h55);
    bus_a.tx_valid = 1'b0;
    check("t1_pre_fall", tx_a, 1'b1);
    check("t1_level1", level_a, 1);
    @(negedge clk);
    check("t1_level0", level_a, 0);
    for (int i = 0; i < 10 * DIV; i++) begin
      check("t1_line", tx_a, (i / DIV) % 2);
      check("t1_busy", busy_a, 1'b1);
      @(negedge clk);
    end
    check("t1_busy_end", busy_a, 1'b0);
    wait_idle();

    // 0x00 then 0xFF with no gap between frames.
    push_a(8'h00);
    push_a(8'hFF);
    bus_a.tx_valid = 1'b0;
    for (int i = 0; i < 20 * DIV; i++) begin
      check("t2_line", tx_a, (i < 10 * DIV) ? ((i / DIV) == 9) : (((i - 10 * DIV) / DIV) != 0));
      @(negedge clk);
    end
    wait_idle();

    // Six bytes with valid held: five fit, the sixth waits for the frame.
    for (int j = 0; j < 5; j++) begin
      push_a(8'h10 + 8'(j));
      if (j == 0) acc1 = last_acc;
    end
    check("t3_full_level", level_a, 4);
    check("t3_full_ready", bus_a.tx_ready, 1'b0);
    push_a(8'h15);
    bus_a.tx_valid = 1'b0;
    check("t3_stall", last_acc - acc1, 10 * DIV + 2);
    wait_idle();

    // Push coinciding with pop at level 2.
    push_a(8'h31);
    push_a(8'h32);
    push_a(8'h33);
    bus_a.tx_valid = 1'b0;
    check("t4_level2", level_a, 2);
    wait_t(10 * DIV - 1);
    bus_a.tx_data  = 8'h34;
    bus_a.tx_valid = 1'b1;
    @(negedge clk);
    bus_a.tx_valid = 1'b0;
    check("t4_level_hold", level_a, 2);
    wait_idle();

    // Reset during data bit 3, then a clean frame.
    push_a(8'hC6);
    push_a(8'h11);
    push_a(8'h22);
    bus_a.tx_valid = 1'b0;
    wait_t(4 * DIV + 1);
    reset_pulse("t5_rst");
    push_a(8'hA3);
    bus_a.tx_valid = 1'b0;
    wait_idle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus_a.tx_valid = ($urandom_range(0, 99) < 30);
      bus_a.tx_data  = 8'($urandom);
      if ($urandom_range(0, 799) == 0) reset_pulse("rnd_rst");
    end
    bus_a.tx_valid = 1'b0;
    wait_idle();

    // Default 9600 baud at 12 MHz, byte 0x41.
    bus_d.tx_data  = 8'h41;
    bus_d.tx_valid = 1'b1;
    check("d_ready", bus_d.tx_ready, 1'b1);
    @(negedge clk);
    bus_d.tx_valid = 1'b0;
    check("d_pre_fall", tx_d, 1'b1);
    @(negedge clk);
    check("d_fall", tx_d, 1'b0);
    sw  = 0;
    rxd = '0;
    s0  = 1'b1;
    s9  = 1'b0;
    for (int c = 0; c <= 10 * DDIV; c++) begin
      if (sw == 0 && tx_d == 1'b1) sw = c;
      if ((c % DDIV) == DDIV / 2) begin
        if (c / DDIV == 0) s0 = tx_d;
        else if (c / DDIV <= 8) rxd[c / DDIV - 1] = tx_d;
        else s9 = tx_d;
      end
      if (c == 10 * DDIV - 1) check("d_busy_last", busy_d, 1'b1);
      if (c == 10 * DDIV) begin
        check("d_busy_end", busy_d, 1'b0);
        check("d_idle_line", tx_d, 1'b1);
      end
      if (c < 10 * DDIV) @(negedge clk);
    end
    check("d_start_width", sw, DDIV);
    check("d_start_bit", s0, 1'b0);
    check("d_byte", rxd, 8'h41);
    check("d_stop_bit", s9, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
